dot_prod_host: RTL and testbench
================================

Name: dot_prod_host

Overview:
- Host-side initiator for the generated dot-product accelerator (module `main`).
- Accepts a stream of (a,b) element pairs and writes them into the accelerator's two arrays through its controlArr write ports.
- Then launches the accelerator with r_enable, waits for w_enable, and returns the 64-bit result on a valid/ready output.
- Sits between the SoC streaming fabric and `main`.

Parameters:
- N, 1000, elements per vector; the accelerator's loop bound.
- AW, 10, array address width.
- DW, 27, signed element width.
- RW, 64, signed result width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  element pair valid
- in_ready  out  1  host accepts pair
- in_a  in  DW  signed element of a
- in_b  in  DW  signed element of b
- acc_init  in  RW  signed initial accumulator, sampled at launch
- out_valid  out  1  result valid
- out_ready  in  1  result consumed
- out_result  out  RW  signed dot product
- out_err  out  1  readback mismatch; tied 0 without the optional feature
- busy  out  1  high in any state except LOAD
- acc_r_enable  out  1  accelerator start pulse
- acc_control_arr  out  1  host owns array ports
- acc_init_i  out  AW  start index, constant 0
- acc_init_acc  out  RW  registered copy of acc_init
- acc_w_enable  in  1  accelerator done
- acc_result  in  RW  accelerator result
- acc_wen_a / acc_wen_b  out  1  array write enables
- acc_addr_a / acc_addr_b  out  AW  array addresses
- acc_wdata_a / acc_wdata_b  out  DW  array write data
- acc_rdata_a / acc_rdata_b  in  DW  array read data; one-cycle read latency

Behaviour:
- Reset values:
  - state=LOAD, idx=0.
  - in_ready=1, out_valid=0, out_result=0, out_err=0.
  - acc_r_enable=0, acc_control_arr=1, wen=0, addr=0, wdata=0, acc_init_acc=0.
- Reset is honoured at any point. A reset mid-load or mid-run discards everything; the next load restarts at address 0.
- All accelerator-facing outputs are registered.
- LOAD:
  - in_ready=1.
  - On in_valid&&in_ready: register wen_a=wen_b=1, addr=idx, wdata=in_a/in_b; idx++.
  - On the cycle no pair is accepted: wen=0.
  - When the accepted pair has idx==N-1: idx=0 and go to DRAIN.
  - in_ready drops the cycle after the N-th accept.
- DRAIN:
  - One cycle; in_ready=0.
  - Lets the final registered write retire.
  - Next state is CHECK if the optional feature is enabled, else LAUNCH.
- LAUNCH:
  - One cycle: acc_r_enable=1, acc_control_arr=0, acc_init_acc=acc_init (acc_init sampled this cycle).
  - Go to SETTLE.
- SETTLE:
  - One cycle; acc_r_enable=0.
  - acc_w_enable is ignored here, because the previous run's w_enable is still visible until the accelerator samples r_enable.
  - Go to WAIT.
- WAIT:
  - acc_control_arr=0.
  - On acc_w_enable=1: capture acc_result into out_result, set out_valid=1, go to DONE.
  - There is no timeout.
- DONE:
  - out_valid held high with out_result stable until out_ready.
  - On out_valid&&out_ready: out_valid=0, out_err=0, acc_control_arr=1, go to LOAD.
  - acc_control_arr returns to 1 on the same edge; the accelerator's terminal state leaves the arrays idle.
- Arithmetic:
  - No arithmetic in this block; the result passes through unmodified.
  - acc_init_i is fixed at 0.
- Simultaneous events:
  - in_valid is never accepted outside LOAD.
  - out_ready outside DONE is ignored.

Optional Feature:
- Macro: DOT_PROD_HOST_READBACK_EN.
- With the macro:
  - During LOAD, keep two DW-bit XOR folds, chk_a^=in_a and chk_b^=in_b. They are cleared on entering LOAD.
  - After DRAIN, a CHECK state issues reads: addr=0..N-1 with wen=0 and acc_control_arr=1.
  - rdata is folded into rchk_a/rchk_b one cycle after each address (N+1 cycles in total).
  - If both folds match, go to LAUNCH.
  - If either differs, skip the launch and go to DONE with out_result=0 and out_err=1.
- Without the macro:
  - No CHECK state and no fold registers.
  - out_err is constant 0.

Decomposition:
- Package dot_prod_pkg holds:
  - N, AW, DW, RW localparams.
  - typedef elem_t (signed DW), res_t (signed RW), addr_t (AW).
  - enum host_state_e {LOAD, DRAIN, CHECK, LAUNCH, SETTLE, WAIT, DONE}.
- Single module; no sub-module is needed.
- The optional readback fold logic stays inline under the macro guard.

Test Plan:
- Load a[i]=i, b[i]=2 for i=0..999, acc_init=0 -> out_result=999000 with out_valid; exactly one acc_r_enable pulse.
- Load all a=-3, b=7, acc_init=5 -> out_result=-20995.
- Random in_valid gaps during load, then out_ready held low 20 cycles after out_valid -> out_result stable and out_valid held; in_ready=0 until handshake, then in_ready=1.
- Assert rst after 500 pairs, then load 1000 pairs a=1, b=1 -> writes restart at addr 0; out_result=1000.
- Back-to-back runs, second with a[i]=1, b[i]=i -> 499500. The stale w_enable from run 1 must not end WAIT early; checked via SETTLE timing.
- With DOT_PROD_HOST_READBACK_EN, the accelerator model flips bit 0 of a[17] after load -> out_err=1, out_result=0, no acc_r_enable pulse.

Source files
------------

// File: rtl/dot_prod_pkg.sv
// Shared sizes, types and host FSM states for the dot-product accelerator host.
package dot_prod_pkg;
  localparam int N  = 1000;
  localparam int AW = 10;
  localparam int DW = 27;
  localparam int RW = 64;

  typedef logic signed [DW-1:0] elem_t;
  typedef logic signed [RW-1:0] res_t;
  typedef logic        [AW-1:0] addr_t;

  typedef enum logic [2:0] {
    LOAD, DRAIN, CHECK, LAUNCH, SETTLE, WAIT, DONE
  } host_state_e;

  localparam addr_t LAST_IDX = addr_t'(N - 1);
  localparam addr_t N_ADDR   = addr_t'(N);
endpackage

// File: rtl/dot_prod_host.sv
// Host initiator: streams (a,b) pairs into the accelerator arrays, launches it and returns the result.
// Define DOT_PROD_HOST_READBACK_EN to verify the loaded arrays by XOR-fold readback before launch.
module dot_prod_host
  import dot_prod_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  input  logic [RW-1:0] acc_init,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_result,
  output logic          out_err,
  output logic          busy,
  output logic          acc_r_enable,
  output logic          acc_control_arr,
  output logic [AW-1:0] acc_init_i,
  output logic [RW-1:0] acc_init_acc,
  input  logic          acc_w_enable,
  input  logic [RW-1:0] acc_result,
  output logic          acc_wen_a,
  output logic          acc_wen_b,
  output logic [AW-1:0] acc_addr_a,
  output logic [AW-1:0] acc_addr_b,
  output logic [DW-1:0] acc_wdata_a,
  output logic [DW-1:0] acc_wdata_b,
  input  logic [DW-1:0] acc_rdata_a,
  input  logic [DW-1:0] acc_rdata_b
);

  host_state_e state_q, state_d;
  addr_t idx_q, idx_d;
  addr_t addr_q, addr_d;
  logic  wen_q, wen_d;
  elem_t wdata_a_q, wdata_a_d, wdata_b_q, wdata_b_d;
  logic  r_en_q, r_en_d;
  logic  ctrl_q, ctrl_d;
  res_t  init_acc_q, init_acc_d;
  logic  out_valid_q, out_valid_d;
  res_t  out_result_q, out_result_d;
  logic  out_err_q, out_err_d;

  logic accept, last_accept;
  assign accept      = in_valid && (state_q == LOAD);
  assign last_accept = accept && (idx_q == LAST_IDX);

`ifdef DOT_PROD_HOST_READBACK_EN
  elem_t chk_a_q, chk_a_d, chk_b_q, chk_b_d;
  elem_t rchk_a_q, rchk_a_d, rchk_b_q, rchk_b_d;
  addr_t rd_cnt_q, rd_cnt_d;
  logic  fold_ok;
  // Decision is taken in the cycle the last read datum arrives, so fold it in here.
  assign fold_ok = ((rchk_a_q ^ elem_t'(acc_rdata_a)) == chk_a_q) &&
                   ((rchk_b_q ^ elem_t'(acc_rdata_b)) == chk_b_q);
`else
  logic unused_rdata;
  assign unused_rdata = ^{acc_rdata_a, acc_rdata_b};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= LOAD;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:   if (last_accept) state_d = DRAIN;
`ifdef DOT_PROD_HOST_READBACK_EN
      DRAIN:  state_d = CHECK;
      CHECK:  if (rd_cnt_q == N_ADDR) state_d = fold_ok ? LAUNCH : DONE;
`else
      DRAIN:  state_d = LAUNCH;
`endif
      LAUNCH: state_d = SETTLE;
      SETTLE: state_d = WAIT;
      WAIT:   if (acc_w_enable) state_d = DONE;
      DONE:   if (out_valid_q && out_ready) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    idx_d        = idx_q;
    addr_d       = addr_q;
    wen_d        = 1'b0;
    wdata_a_d    = wdata_a_q;
    wdata_b_d    = wdata_b_q;
    r_en_d       = 1'b0;
    ctrl_d       = ctrl_q;
    init_acc_d   = init_acc_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_err_d    = out_err_q;
`ifdef DOT_PROD_HOST_READBACK_EN
    chk_a_d  = chk_a_q;
    chk_b_d  = chk_b_q;
    rchk_a_d = rchk_a_q;
    rchk_b_d = rchk_b_q;
    rd_cnt_d = rd_cnt_q;
`endif
    case (state_q)
      LOAD: begin
        if (accept) begin
          wen_d     = 1'b1;
          addr_d    = idx_q;
          wdata_a_d = elem_t'(in_a);
          wdata_b_d = elem_t'(in_b);
          idx_d     = last_accept ? '0 : idx_q + addr_t'(1);
`ifdef DOT_PROD_HOST_READBACK_EN
          chk_a_d   = chk_a_q ^ elem_t'(in_a);
          chk_b_d   = chk_b_q ^ elem_t'(in_b);
`endif
        end
      end
`ifdef DOT_PROD_HOST_READBACK_EN
      DRAIN: begin
        addr_d   = '0;
        rd_cnt_d = '0;
        rchk_a_d = '0;
        rchk_b_d = '0;
      end
      CHECK: begin
        if (rd_cnt_q != N_ADDR) begin
          rd_cnt_d = rd_cnt_q + addr_t'(1);
          addr_d   = (rd_cnt_q < LAST_IDX) ? rd_cnt_q + addr_t'(1) : '0;
        end
        if (rd_cnt_q != '0) begin
          rchk_a_d = rchk_a_q ^ elem_t'(acc_rdata_a);
          rchk_b_d = rchk_b_q ^ elem_t'(acc_rdata_b);
        end
        if (rd_cnt_q == N_ADDR && !fold_ok) begin
          out_result_d = '0;
          out_err_d    = 1'b1;
          out_valid_d  = 1'b1;
        end
      end
`endif
      LAUNCH: begin
        r_en_d     = 1'b1;
        ctrl_d     = 1'b0;
        init_acc_d = res_t'(acc_init);
      end
      WAIT: begin
        ctrl_d = 1'b0;
        if (acc_w_enable) begin
          out_result_d = res_t'(acc_result);
          out_valid_d  = 1'b1;
        end
      end
      DONE: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          out_err_d   = 1'b0;
          ctrl_d      = 1'b1;
`ifdef DOT_PROD_HOST_READBACK_EN
          chk_a_d     = '0;
          chk_b_d     = '0;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q        <= '0;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_a_q    <= '0;
      wdata_b_q    <= '0;
      r_en_q       <= 1'b0;
      ctrl_q       <= 1'b1;
      init_acc_q   <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_err_q    <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_a_q    <= wdata_a_d;
      wdata_b_q    <= wdata_b_d;
      r_en_q       <= r_en_d;
      ctrl_q       <= ctrl_d;
      init_acc_q   <= init_acc_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_err_q    <= out_err_d;
    end
  end

`ifdef DOT_PROD_HOST_READBACK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_a_q  <= '0;
      chk_b_q  <= '0;
      rchk_a_q <= '0;
      rchk_b_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      chk_a_q  <= chk_a_d;
      chk_b_q  <= chk_b_d;
      rchk_a_q <= rchk_a_d;
      rchk_b_q <= rchk_b_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end
`endif

  assign in_ready        = (state_q == LOAD);
  assign busy            = (state_q != LOAD);
  assign out_valid       = out_valid_q;
  assign out_result      = out_result_q;
  assign out_err         = out_err_q;
  assign acc_r_enable    = r_en_q;
  assign acc_control_arr = ctrl_q;
  assign acc_init_i      = '0;
  assign acc_init_acc    = init_acc_q;
  assign acc_wen_a       = wen_q;
  assign acc_wen_b       = wen_q;
  assign acc_addr_a      = addr_q;
  assign acc_addr_b      = addr_q;
  assign acc_wdata_a     = wdata_a_q;
  assign acc_wdata_b     = wdata_b_q;

endmodule

// File: tb/tb_dot_prod_host.sv
// Directed bench for dot_prod_host with a behavioural accelerator (arrays + delayed result).
module tb_dot_prod_host;
  import dot_prod_pkg::*;

  localparam int LAT = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;
  logic [RW-1:0] acc_init = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [RW-1:0] out_result;
  logic          out_err;
  logic          busy;
  logic          acc_r_enable;
  logic          acc_control_arr;
  logic [AW-1:0] acc_init_i;
  logic [RW-1:0] acc_init_acc;
  logic          acc_w_enable;
  logic [RW-1:0] acc_result;
  logic          acc_wen_a, acc_wen_b;
  logic [AW-1:0] acc_addr_a, acc_addr_b;
  logic [DW-1:0] acc_wdata_a, acc_wdata_b;
  logic [DW-1:0] acc_rdata_a, acc_rdata_b;

  dot_prod_host dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .acc_init(acc_init),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_err(out_err),
    .busy(busy),
    .acc_r_enable(acc_r_enable), .acc_control_arr(acc_control_arr),
    .acc_init_i(acc_init_i), .acc_init_acc(acc_init_acc),
    .acc_w_enable(acc_w_enable), .acc_result(acc_result),
    .acc_wen_a(acc_wen_a), .acc_wen_b(acc_wen_b),
    .acc_addr_a(acc_addr_a), .acc_addr_b(acc_addr_b),
    .acc_wdata_a(acc_wdata_a), .acc_wdata_b(acc_wdata_b),
    .acc_rdata_a(acc_rdata_a), .acc_rdata_b(acc_rdata_b)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Accelerator model
  elem_t mem_a [N];
  elem_t mem_b [N];
  logic  model_w_en = 1'b0;
  res_t  model_result = '0;
  res_t  pend = '0;
  res_t  sum_v;
  int    busy_cnt = 0;
  int    wr_count = 0;
  int    first_wr_addr = -1;
  int    last_wr_addr = -1;
  int    r_pulses = 0;
  bit    flip_req = 1'b0;

  assign acc_w_enable = model_w_en;
  assign acc_result   = model_result;

  always @(posedge clk) begin
    if (acc_control_arr && acc_wen_a) begin
      mem_a[acc_addr_a] <= elem_t'(acc_wdata_a);
      mem_b[acc_addr_b] <= elem_t'(acc_wdata_b);
      if (wr_count == 0) first_wr_addr = int'(acc_addr_a);
      last_wr_addr = int'(acc_addr_a);
      wr_count = wr_count + 1;
    end
    if (flip_req) begin
      mem_a[17][0] <= ~mem_a[17][0];
      flip_req = 1'b0;
    end
    acc_rdata_a <= mem_a[acc_addr_a];
    acc_rdata_b <= mem_b[acc_addr_b];
    if (acc_r_enable) begin
      r_pulses = r_pulses + 1;
      sum_v = res_t'(acc_init_acc);
      for (int i = 0; i < N; i++) sum_v = sum_v + longint'(mem_a[i]) * longint'(mem_b[i]);
      pend       <= sum_v;
      model_w_en <= 1'b0;
      busy_cnt   <= LAT;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else if (busy_cnt == 1) begin
      model_w_en   <= 1'b1;
      model_result <= pend;
      busy_cnt     <= 0;
    end
  end

  task automatic feed(input int mode, input int count, input bit gaps);
    for (int i = 0; i < count; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      in_valid = 1'b1;
      case (mode)
        0:       begin in_a = DW'(i);  in_b = DW'(2); end
        1:       begin in_a = DW'(-3); in_b = DW'(7); end
        2:       begin in_a = DW'(1);  in_b = DW'(1); end
        default: begin in_a = DW'(1);  in_b = DW'(i); end
      endcase
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input res_t exp, input string tag);
    int t;
    int t_r;
    t = 0;
    t_r = -1;
    while (out_valid !== 1'b1 && t < 6000) begin
      if (acc_r_enable === 1'b1 && t_r < 0) begin
        t_r = t;
        total++;
        if (acc_control_arr !== 1'b0)
          $display("FAIL %s ctrl_arr_during_run got %b exp 0", tag, acc_control_arr);
        else passed++;
      end
      @(negedge clk);
      t++;
    end
    total++;
    if (out_valid !== 1'b1) $display("FAIL %s out_valid_timeout got %b exp 1", tag, out_valid);
    else passed++;
    total++;
    if (out_result !== exp) $display("FAIL %s out_result got %0d exp %0d", tag, $signed(out_result), exp);
    else passed++;
    total++;
    if (t - t_r !== LAT + 2) $display("FAIL %s launch_to_valid got %0d exp %0d", tag, t - t_r, LAT + 2);
    else passed++;
    total++;
    if (r_pulses !== 1) $display("FAIL %s r_enable_pulses got %0d exp 1", tag, r_pulses);
    else passed++;
    total++;
    if (out_err !== 1'b0) $display("FAIL %s out_err got %b exp 0", tag, out_err);
    else passed++;
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0) $display("FAIL %s out_valid_after_hs got %b exp 0", tag, out_valid);
    else passed++;
    total++;
    if (in_ready !== 1'b1) $display("FAIL %s in_ready_after_hs got %b exp 1", tag, in_ready);
    else passed++;
    total++;
    if (acc_control_arr !== 1'b1) $display("FAIL %s ctrl_arr_after_hs got %b exp 1", tag, acc_control_arr);
    else passed++;
  endtask

  task automatic check_reset_values(input string tag);
    total++;
    if (in_ready !== 1'b1) $display("FAIL %s in_ready got %b exp 1", tag, in_ready); else passed++;
    total++;
    if (out_valid !== 1'b0) $display("FAIL %s out_valid got %b exp 0", tag, out_valid); else passed++;
    total++;
    if (out_result !== '0) $display("FAIL %s out_result got %0d exp 0", tag, out_result); else passed++;
    total++;
    if (out_err !== 1'b0) $display("FAIL %s out_err got %b exp 0", tag, out_err); else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL %s busy got %b exp 0", tag, busy); else passed++;
    total++;
    if (acc_r_enable !== 1'b0) $display("FAIL %s r_enable got %b exp 0", tag, acc_r_enable); else passed++;
    total++;
    if (acc_control_arr !== 1'b1) $display("FAIL %s ctrl_arr got %b exp 1", tag, acc_control_arr); else passed++;
    total++;
    if ({acc_wen_a, acc_wen_b} !== 2'b00) $display("FAIL %s wen got %b exp 00", tag, {acc_wen_a, acc_wen_b}); else passed++;
    total++;
    if ({acc_addr_a, acc_addr_b} !== '0) $display("FAIL %s addr got %0h exp 0", tag, {acc_addr_a, acc_addr_b}); else passed++;
    total++;
    if ({acc_wdata_a, acc_wdata_b} !== '0) $display("FAIL %s wdata got %0h exp 0", tag, {acc_wdata_a, acc_wdata_b}); else passed++;
    total++;
    if (acc_init_acc !== '0) $display("FAIL %s init_acc got %0d exp 0", tag, acc_init_acc); else passed++;
    total++;
    if (acc_init_i !== '0) $display("FAIL %s init_i got %0d exp 0", tag, acc_init_i); else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("reset_held");
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("reset_released");
  endtask

  task automatic test_ramp();
    acc_init = '0;
    r_pulses = 0;
    feed(0, N, 1'b0);
    total++;
    if (in_ready !== 1'b0) $display("FAIL ramp in_ready_after_last got %b exp 0", in_ready);
    else passed++;
    wait_result(res_t'(999000), "ramp");
    handshake("ramp");
  endtask

  task automatic test_const();
    acc_init = RW'(5);
    r_pulses = 0;
    feed(1, N, 1'b0);
    wait_result(-res_t'(20995), "const");
    handshake("const");
  endtask

  task automatic test_gaps_hold();
    int bad;
    acc_init = RW'(5);
    r_pulses = 0;
    feed(1, N, 1'b1);
    wait_result(-res_t'(20995), "gaps");
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_result !== -res_t'(20995) || in_ready !== 1'b0 || busy !== 1'b1)
        bad++;
    end
    total++;
    if (bad !== 0) $display("FAIL hold_stable bad_cycles got %0d exp 0", bad);
    else passed++;
    handshake("gaps");
  endtask

  task automatic test_reset_mid_load();
    acc_init = '0;
    feed(2, 500, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || acc_wen_a !== 1'b0)
      $display("FAIL midrst state got ready=%b busy=%b wen=%b exp 1/0/0", in_ready, busy, acc_wen_a);
    else passed++;
    wr_count = 0;
    r_pulses = 0;
    feed(2, N, 1'b0);
    wait_result(res_t'(1000), "midrst");
    total++;
    if (first_wr_addr !== 0) $display("FAIL midrst first_wr_addr got %0d exp 0", first_wr_addr);
    else passed++;
    total++;
    if (wr_count !== N) $display("FAIL midrst wr_count got %0d exp %0d", wr_count, N);
    else passed++;
    total++;
    if (last_wr_addr !== N - 1) $display("FAIL midrst last_wr_addr got %0d exp %0d", last_wr_addr, N - 1);
    else passed++;
    handshake("midrst");
  endtask

  task automatic test_back_to_back();
    acc_init = '0;
    r_pulses = 0;
    feed(0, N, 1'b0);
    wait_result(res_t'(999000), "b2b_1");
    handshake("b2b_1");
    r_pulses = 0;
    feed(3, N, 1'b0);
    wait_result(res_t'(499500), "b2b_2");
    handshake("b2b_2");
  endtask

`ifdef DOT_PROD_HOST_READBACK_EN
  task automatic test_readback();
    int t;
    acc_init = '0;
    r_pulses = 0;
    feed(2, N, 1'b0);
    flip_req = 1'b1;
    t = 0;
    while (out_valid !== 1'b1 && t < 6000) begin
      @(negedge clk);
      t++;
    end
    total++;
    if (out_valid !== 1'b1) $display("FAIL readback out_valid_timeout got %b exp 1", out_valid); else passed++;
    total++;
    if (out_err !== 1'b1) $display("FAIL readback out_err got %b exp 1", out_err); else passed++;
    total++;
    if (out_result !== '0) $display("FAIL readback out_result got %0d exp 0", out_result); else passed++;
    total++;
    if (r_pulses !== 0) $display("FAIL readback r_enable_pulses got %0d exp 0", r_pulses); else passed++;
    handshake("readback");
    total++;
    if (out_err !== 1'b0) $display("FAIL readback out_err_after_hs got %b exp 0", out_err); else passed++;
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_ramp();
    test_const();
    test_gaps_hold();
    test_reset_mid_load();
    test_back_to_back();
`ifdef DOT_PROD_HOST_READBACK_EN
    test_readback();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
